toy_alu_seq: RTL and testbench

//  WIDTH-bit sequential ALU for the ToyProcessor datapath.
//  - Replaces the 1-bit arithmetic/logic extender + adder slice with a parametrised vector ALU.
//  - Registers its result and flags, and adds an iterative shift-add multiply mode.
//  - Sits between register-file read and write-back; valid/ready handshake on both sides.

---
 rtl/toy_alu_pkg.sv | 28 ++
 rtl/toy_alu_seq_ae_le_vec.sv | 43 ++++
 rtl/toy_alu_seq.sv | 145 ++++++++++++++
 tb/tb_toy_alu_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/toy_alu_pkg.sv
// Shared definitions for the ToyProcessor sequential ALU.
// - op field bit positions: op = {MUL, M, S1, S0}
// - full 4-bit opcode values for every supported operation
// - FSM state encoding used by toy_alu_seq
package toy_alu_pkg;

  localparam int OP_MUL_BIT = 3;
  localparam int OP_M_BIT   = 2;
  localparam int OP_S1_BIT  = 1;
  localparam int OP_S0_BIT  = 0;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_NOT = 4'b0011;
  localparam logic [3:0] OP_INC = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_DEC = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/toy_alu_seq_ae_le_vec.sv
// Combinational arithmetic/logic extender (vector form of the old 1-bit slice).
// Ports:
//   a, b   in  WIDTH  operands
//   m      in  1      1 = arithmetic, 0 = logic
//   s1,s0  in  1      operation select
//   y      out WIDTH  extended B fed to the adder (arith only, else 0)
//   c0     out 1      adder carry-in (arith only, else 0)
//   lres   out WIDTH  logic result (logic only, else 0)
module ae_le_vec #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  input  logic             s1,
  input  logic             s0,
  output logic [WIDTH-1:0] y,
  output logic             c0,
  output logic [WIDTH-1:0] lres
);
  import toy_alu_pkg::*;

  always_comb begin
    y    = '0;
    c0   = 1'b0;
    lres = '0;
    case ({m, s1, s0})
      OP_INC[2:0]: c0 = 1'b1;
      OP_ADD[2:0]: y = b;
      OP_SUB[2:0]: begin
        y  = ~b;
        c0 = 1'b1;
      end
      OP_DEC[2:0]: y = '1;
      OP_AND[2:0]: lres = a & b;
      OP_OR[2:0]:  lres = a | b;
      OP_XOR[2:0]: lres = a ^ b;
      OP_NOT[2:0]: lres = ~a;
      default: ;
    endcase
  end

endmodule

// File: rtl/toy_alu_seq.sv
// WIDTH-bit sequential ALU with registered result/flags and an iterative
// shift-add multiplier (WIDTH cycles). valid/ready handshake on both sides.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     request handshake (in_ready = state IDLE)
//   a, b, op              operands and opcode {MUL,M,S1,S0}
//   out_valid/out_ready   result handshake, result held until taken
//   result, result_hi     result (low/high halves of product for MUL)
//   flag_c/z/n/v          carry, zero, negative, signed overflow
module toy_alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);
  import toy_alu_pkg::*;

  state_t state, state_nxt;

  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] lres;
  logic             c0;
  logic [WIDTH:0]   sum;
  logic             c_into_msb;
  logic [WIDTH-1:0] alu_res;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     partial;
  logic [CNT_W-1:0]   cnt;
  logic               last_step;

  ae_le_vec #(.WIDTH(WIDTH)) u_ext (
    .a   (a),
    .b   (b),
    .m   (op[OP_M_BIT]),
    .s1  (op[OP_S1_BIT]),
    .s0  (op[OP_S0_BIT]),
    .y   (y),
    .c0  (c0),
    .lres(lres)
  );

  always_comb begin
    sum        = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, c0};
    // carry into the MSB recovered from the sum bit: s = a ^ y ^ cin
    c_into_msb = a[WIDTH-1] ^ y[WIDTH-1] ^ sum[WIDTH-1];
    alu_res    = op[OP_M_BIT] ? sum[WIDTH-1:0] : lres;
  end

  // Right-shifting shift-add: the upper half accumulates, each step shifts the
  // finished low bit into the lower half, so after WIDTH steps product = A*B.
  always_comb begin
    partial   = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    prod_step = {partial, product[WIDTH-1:1]};
    last_step = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = op[OP_MUL_BIT] ? ST_MUL : ST_HOLD;
      ST_MUL:  if (last_step) state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      product   <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (op[OP_MUL_BIT]) begin
              mcand   <= a;
              mplier  <= b;
              product <= '0;
              cnt     <= '0;
            end else begin
              result    <= alu_res;
              result_hi <= '0;
              flag_c    <= op[OP_M_BIT] & sum[WIDTH];
              flag_v    <= op[OP_M_BIT] & (c_into_msb ^ sum[WIDTH]);
              flag_z    <= (alu_res == '0);
              flag_n    <= alu_res[WIDTH-1];
              out_valid <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          product <= prod_step;
          mplier  <= mplier >> 1;
          cnt     <= cnt + 1'b1;
          if (last_step) begin
            result    <= prod_step[WIDTH-1:0];
            result_hi <= prod_step[2*WIDTH-1:WIDTH];
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_z    <= (prod_step == '0);
            flag_n    <= prod_step[2*WIDTH-1];
            out_valid <= 1'b1;
          end
        end
        ST_HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_toy_alu_seq.sv
module tb_toy_alu_seq;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [3:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       flag_c, flag_z, flag_n, flag_v;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  vec_t vecs[24];

  toy_alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .result_hi(result_hi),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_v   (flag_v)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic [3:0] mop);
    exp_t e;
    int ua, ub, sa, sb, r, s;
    e  = '0;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    r  = 0;
    s  = 0;
    if (mop[3]) begin
      r    = ua * ub;
      e.res = r[7:0];
      e.hi  = r[15:8];
      e.z   = (r == 0);
      e.n   = r[15];
    end else begin
      if (mop[2]) begin
        case (mop[1:0])
          2'd0: begin r = ua + 1;  s = sa + 1;  e.c = (r > 255); end
          2'd1: begin r = ua + ub; s = sa + sb; e.c = (r > 255); end
          2'd2: begin r = ua - ub; s = sa - sb; e.c = (r >= 0);  end
          default: begin r = ua - 1; s = sa - 1; e.c = (r >= 0); end
        endcase
        e.res = r[7:0];
        e.v   = (s > 127) || (s < -128);
      end else begin
        case (mop[1:0])
          2'd0: e.res = ma & mb;
          2'd1: e.res = ma | mb;
          2'd2: e.res = ma ^ mb;
          default: e.res = ~ma;
        endcase
      end
      e.z = (e.res == 8'h00);
      e.n = e.res[7];
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vop, input exp_t e);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 16'(in_ready), 16'd1);
    a        = va;
    b        = vb;
    op       = vop;
    in_valid = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input string name);
    int   n = 0;
    exp_t e;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      check({name, "_valid_timeout"}, 16'(out_valid), 16'd1);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      check({name, "_res"}, {result_hi, result}, {e.hi, e.res});
      check({name, "_czvn"}, 16'({flag_c, flag_z, flag_n, flag_v}), 16'({e.c, e.z, e.n, e.v}));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, "_taken"}, 16'({out_valid, in_ready}), 16'b01);
    end
  endtask

  initial begin
    int   n;
    exp_t e;

    for (int unsigned i = 0; i < 16; i++) begin
      vecs[i].a  = 8'h5A;
      vecs[i].b  = 8'h3C;
      vecs[i].op = 4'(i);
      vecs[i].e  = model(8'h5A, 8'h3C, 4'(i));
    end
    // res, hi, c, z, n, v
    vecs[16] = '{8'h7F, 8'h01, 4'b0101, '{8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[17] = '{8'h05, 8'h05, 4'b0110, '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[18] = '{8'hFF, 8'hFF, 4'b1000, '{8'h01, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[19] = '{8'h00, 8'h37, 4'b1111, '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[20] = '{8'h00, 8'h00, 4'b0111, '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[21] = '{8'hFF, 8'h00, 4'b0100, '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[22] = '{8'h7F, 8'h00, 4'b0100, '{8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[23] = '{8'h80, 8'h01, 4'b0110, '{8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1}};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_hs", 16'({in_ready, out_valid}), 16'b10);
    check("reset_res", {result_hi, result}, 16'h0000);
    check("reset_flags", 16'({flag_c, flag_z, flag_n, flag_v}), 16'h0);

    for (int unsigned i = 0; i < 24; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].e);
      collect($sformatf("vec%0d", i));
    end

    // MUL latency: out_valid exactly WIDTH edges after the accept edge
    send(8'hFF, 8'hFF, 4'b1000, '{8'h01, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0});
    n = 0;
    while (!out_valid && n < 40) begin
      check("mul_busy_in_ready", 16'(in_ready), 16'd0);
      @(posedge clk); #1;
      n++;
    end
    check("mul_latency", 16'(n), 16'd8);
    collect("mul_ffff");

    // Backpressure: held result must stay put and ignore new requests
    send(8'h12, 8'h34, 4'b0101, model(8'h12, 8'h34, 4'b0101));
    a        = 8'hAA;
    b        = 8'h55;
    op       = 4'b1000;
    in_valid = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hs", 16'({out_valid, in_ready}), 16'b10);
      check("bp_res", {result_hi, result}, 16'h0046);
    end
    in_valid = 1'b0;
    collect("bp_take");
    check("bp_queue_empty", 16'(sb_q.size()), 16'd0);

    // Reset during MUL step 3 aborts the multiply
    send(8'h09, 8'h07, 4'b1000, model(8'h09, 8'h07, 4'b1000));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb_q.pop_back());
    check("rst_mid_hs", 16'({in_ready, out_valid}), 16'b10);
    check("rst_mid_res", {result_hi, result}, 16'h0000);
    send(8'h21, 8'h13, 4'b0110, model(8'h21, 8'h13, 4'b0110));
    collect("after_rst");

    // Operand changes during MUL must not disturb the in-flight product
    send(8'hC3, 8'h5D, 4'b1000, model(8'hC3, 8'h5D, 4'b1000));
    for (int unsigned i = 0; i < 5; i++) begin
      a  = ~a;
      b  = 8'($urandom);
      op = 4'($urandom);
      @(posedge clk); #1;
    end
    collect("mul_toggle");
    e = model(8'hC3, 8'h5D, 4'b1000);
    check("mul_toggle_model", {e.hi, e.res}, 16'h46D7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
